program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 17 +
 rtl/program_loader.sv | 100 ++++++++++
 tb/tb_program_loader.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and defaults for the program loader
package loader_pkg;

   localparam int WORDS_DEF = 1024;
   localparam int WIDTH_DEF = 32;
   localparam int CNT_W     = $clog2(WORDS_DEF) + 1;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      LOAD,
      CSUM,
      DONE,
      ERR
   } state_e;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a length/payload/checksum image into instruction memory
// and releases the CPU from reset once the XOR checksum verifies.
module program_loader
   import loader_pkg::*;
#(
   parameter int WORDS = WORDS_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ready,
   output logic [WORDS*WIDTH-1:0]   instruction_stream,
   output logic                     cpu_hold,
   output logic                     done,
   output logic                     error
);

   localparam int CW = $clog2(WORDS) + 1;

   state_e                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [CW-1:0]            len_q, len_d;
   logic [WIDTH-1:0]         csum_q, csum_d;
   logic [WORDS*WIDTH-1:0]   mem_q, mem_d;
   logic                     xfer;

   assign in_ready           = (state_q == LEN) || (state_q == LOAD) || (state_q == CSUM);
   assign xfer               = in_valid && in_ready;
   assign done               = (state_q == DONE);
   assign cpu_hold           = (state_q != DONE);
   assign error              = (state_q == ERR);
   assign instruction_stream = mem_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      csum_d  = csum_q;
      mem_d   = mem_q;
      // start wins over any word presented on the same edge
      if (start) begin
         state_d = LEN;
         cnt_d   = '0;
         len_d   = '0;
         csum_d  = '0;
         mem_d   = '0;
      end else begin
         case (state_q)
            LEN: begin
               if (xfer) begin
                  if ((in_data != '0) && (in_data <= WIDTH'(WORDS))) begin
                     len_d   = in_data[CW-1:0];
                     state_d = LOAD;
                  end else begin
                     state_d = ERR;
                  end
               end
            end
            LOAD: begin
               if (xfer) begin
                  mem_d[int'(cnt_q)*WIDTH +: WIDTH] = in_data;
                  csum_d = csum_q ^ in_data;
                  // hold the index on the last word so it never passes N-1
                  if (cnt_q == len_q - 1'b1) begin
                     state_d = CSUM;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            CSUM: begin
               if (xfer) begin
                  state_d = (in_data == csum_q) ? DONE : ERR;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         csum_q  <= '0;
         mem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         csum_q  <= csum_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;

   localparam int WORDS = 1024;
   localparam int WIDTH = 32;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   start = 1'b0;
   logic                   in_valid = 1'b0;
   logic [WIDTH-1:0]       in_data = '0;
   logic                   in_ready;
   logic [WORDS*WIDTH-1:0] instruction_stream;
   logic                   cpu_hold;
   logic                   done;
   logic                   error;

   program_loader #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .in_valid           (in_valid),
      .in_data            (in_data),
      .in_ready           (in_ready),
      .instruction_stream (instruction_stream),
      .cpu_hold           (cpu_hold),
      .done               (done),
      .error              (error)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] pay [WORDS];
   logic [31:0] exp_mem [WORDS];

   typedef struct packed {
      logic [31:0]       n;
      logic [31:0]       npay;
      logic [3:0][31:0]  w;
      logic [31:0]       csum;
      logic              exp_done;
      logic              exp_err;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input int i);
      return instruction_stream[i*WIDTH +: WIDTH];
   endfunction

   task automatic check_mem(input string name);
      int bad = 0;
      int first = 0;
      for (int i = 0; i < WORDS; i++) begin
         if (word_at(i) !== exp_mem[i]) begin
            if (bad == 0) first = i;
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s: %0d words differ, word[%0d] got 0x%08h expected 0x%08h",
                  name, bad, first, word_at(first), exp_mem[first]);
      end
   endtask

   task automatic check_flags(input string name, input logic e_done, input logic e_err);
      chk({name, "_done"}, 32'(done), 32'(e_done));
      chk({name, "_error"}, 32'(error), 32'(e_err));
      chk({name, "_cpu_hold"}, 32'(cpu_hold), 32'(!e_done));
      chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // returns 1ns after the edge on which the word was taken
   task automatic send_word(input logic [31:0] d, input bit gap);
      int t = 0;
      @(negedge clk);
      if (gap) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready got 0 expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic run_load(input logic [31:0] n, input logic [31:0] csum, input bit gap);
      pulse_start();
      send_word(n, 1'b0);
      if (n >= 1 && n <= WORDS) begin
         for (int i = 0; i < int'(n); i++) send_word(pay[i], gap);
         send_word(csum, gap);
      end
   endtask

   // reference: after a load, memory holds exactly the first N words and done iff XOR matches
   task automatic model(input logic [31:0] n, input logic [31:0] csum,
                        output logic e_done, output logic e_err);
      logic [31:0] x = '0;
      for (int i = 0; i < WORDS; i++) exp_mem[i] = '0;
      if (n >= 1 && n <= WORDS) begin
         for (int i = 0; i < int'(n); i++) begin
            exp_mem[i] = pay[i];
            x ^= pay[i];
         end
         e_done = (csum == x);
      end else begin
         e_done = 1'b0;
      end
      e_err = !e_done;
   endtask

   initial begin
      logic        e_done, e_err;
      logic [31:0] n, csum, x;
      int          bad;

      tbl[0] = '{n:32'd3, npay:32'd3, w:{32'h0, 32'h01095020, 32'h20090007, 32'h20080005},
                 csum:32'h01085022, exp_done:1'b1, exp_err:1'b0};
      tbl[1] = '{n:32'd3, npay:32'd3, w:{32'h0, 32'h01095020, 32'h20090007, 32'h20080005},
                 csum:32'h0110F032, exp_done:1'b0, exp_err:1'b1};
      tbl[2] = '{n:32'd3, npay:32'd3, w:{32'h0, 32'h01095020, 32'h20090007, 32'h20080005},
                 csum:32'h00000000, exp_done:1'b0, exp_err:1'b1};
      tbl[3] = '{n:32'd0, npay:32'd0, w:'0, csum:32'h0, exp_done:1'b0, exp_err:1'b1};
      tbl[4] = '{n:32'd1025, npay:32'd0, w:'0, csum:32'h0, exp_done:1'b0, exp_err:1'b1};
      tbl[5] = '{n:32'd1, npay:32'd1, w:{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF},
                 csum:32'hFFFFFFFF, exp_done:1'b1, exp_err:1'b0};

      // reset state
      #12;
      for (int i = 0; i < WORDS; i++) exp_mem[i] = '0;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      check_mem("rst_mem");
      @(negedge clk);
      rst = 1'b1;

      // idle ignores traffic until start
      in_valid = 1'b1;
      in_data  = 32'h12345678;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (in_ready !== 1'b0 || cpu_hold !== 1'b1) bad++;
      end
      in_valid = 1'b0;
      chk("idle_no_ready", 32'(bad), 32'd0);
      check_mem("idle_mem");

      // table-driven loads
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 4; i++) pay[i] = tbl[v].w[i];
         for (int i = 0; i < WORDS; i++) exp_mem[i] = (i < int'(tbl[v].npay) && i < 4) ? tbl[v].w[i] : '0;
         run_load(tbl[v].n, tbl[v].csum, 1'b0);
         check_flags($sformatf("tbl%0d", v), tbl[v].exp_done, tbl[v].exp_err);
         check_mem($sformatf("tbl%0d_mem", v));
         chk($sformatf("tbl%0d_word3", v), word_at(3), 32'h0);
      end

      // ERR holds for 20 cycles regardless of input traffic
      for (int i = 0; i < 4; i++) pay[i] = tbl[2].w[i];
      model(32'd3, 32'h0, e_done, e_err);
      run_load(32'd3, 32'h0, 1'b0);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         in_valid = c[0];
         in_data  = $urandom;
         if (error !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      in_valid = 1'b0;
      chk("err_hold_20", 32'(bad), 32'd0);
      check_mem("err_hold_mem");

      // full-depth load with in_valid every other cycle
      x = '0;
      for (int i = 0; i < WORDS; i++) begin
         pay[i] = $urandom;
         x ^= pay[i];
      end
      model(32'(WORDS), x, e_done, e_err);
      run_load(32'(WORDS), x, 1'b1);
      check_flags("full", e_done, e_err);
      check_mem("full_mem");
      chk("full_top_word", instruction_stream[32767:32736], pay[1023]);

      // abort mid-LOAD with a word presented on the start edge, then N=1 load
      pay[0] = 32'hA0A0A0A0; pay[1] = 32'hB1B1B1B1;
      pulse_start();
      send_word(32'd5, 1'b0);
      send_word(pay[0], 1'b0);
      send_word(pay[1], 1'b0);
      @(negedge clk);
      start = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_word0_cleared", word_at(0), 32'h0);
      send_word(32'd1, 1'b0);
      send_word(32'hFFFFFFFF, 1'b0);
      send_word(32'hFFFFFFFF, 1'b0);
      chk("abort_word0", word_at(0), 32'hFFFFFFFF);
      chk("abort_word1", word_at(1), 32'h0);
      check_flags("abort", 1'b1, 1'b0);

      // asynchronous reset between edges mid-LOAD
      for (int i = 0; i < 8; i++) pay[i] = $urandom;
      pulse_start();
      send_word(32'd8, 1'b0);
      for (int i = 0; i < 3; i++) send_word(pay[i], 1'b0);
      #2;
      rst = 1'b0;
      #1;
      for (int i = 0; i < WORDS; i++) exp_mem[i] = '0;
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      chk("arst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_error", 32'(error), 32'd0);
      check_mem("arst_mem");
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b1; in_data = 32'h55AA55AA;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || error !== 1'b0) bad++;
      end
      in_valid = 1'b0;
      chk("arst_stays_idle", 32'(bad), 32'd0);

      // randomized loads against the reference model
      for (int it = 0; it < 10; it++) begin
         case ($urandom % 8)
            0:       n = 32'd0;
            1:       n = 32'(WORDS + 1 + ($urandom % 100));
            default: n = 32'($urandom_range(1, 24));
         endcase
         x = '0;
         for (int i = 0; i < 24; i++) pay[i] = $urandom;
         for (int i = 0; i < 24 && i < int'(n); i++) x ^= pay[i];
         csum = (($urandom % 3) == 0) ? (x ^ (32'h1 << ($urandom % 32))) : x;
         model(n, csum, e_done, e_err);
         run_load(n, csum, 1'($urandom % 2));
         check_flags($sformatf("rand%0d", it), e_done, e_err);
         check_mem($sformatf("rand%0d_mem", it));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation time got 5ms expected less");
      $fatal(1);
   end

endmodule
